bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb_pkg.sv | 43 ++++
 rtl/bus_arb_prio.sv | 25 ++
 rtl/bus_arb.sv | 128 ++++++++++++
 tb/tb_bus_arb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: owner encodings, FSM states,
// request slot ordering and the default burst limit.
package bus_arb_pkg;

    localparam int unsigned BURST_MAX_DEF = 16;
    localparam int unsigned NUM_REQ       = 6;

    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_OP   = 3'd1;
    localparam logic [2:0] OWN_BLIT = 3'd2;
    localparam logic [2:0] OWN_DSP  = 3'd3;
    localparam logic [2:0] OWN_GPU  = 3'd4;
    localparam logic [2:0] OWN_CPU  = 3'd5;

    // Request vector slots, highest priority at bit 0
    localparam int unsigned RQ_OP      = 0;
    localparam int unsigned RQ_BLIT_HI = 1;
    localparam int unsigned RQ_DSP     = 2;
    localparam int unsigned RQ_GPU     = 3;
    localparam int unsigned RQ_BLIT_LO = 4;
    localparam int unsigned RQ_CPU     = 5;

    localparam logic [NUM_REQ-1:0] BLIT_MASK = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Grant vector bit order: {cpu, gpu, dsp, blit, op}
    function automatic logic [4:0] owner_onehot(input logic [2:0] own);
        case (own)
            OWN_OP:   return 5'b00001;
            OWN_BLIT: return 5'b00010;
            OWN_DSP:  return 5'b00100;
            OWN_GPU:  return 5'b01000;
            OWN_CPU:  return 5'b10000;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/bus_arb_prio.sv
// Combinational fixed-priority encoder: masked request vector in,
// winning owner encoding out (OWN_NONE when nobody eligible).
module bus_arb_prio
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [2:0]         winner
);

    logic [NUM_REQ-1:0] eff;

    assign eff = req & ~mask;

    always_comb begin
        winner = OWN_NONE;
        if      (eff[RQ_OP])      winner = OWN_OP;
        else if (eff[RQ_BLIT_HI]) winner = OWN_BLIT;
        else if (eff[RQ_DSP])     winner = OWN_DSP;
        else if (eff[RQ_GPU])     winner = OWN_GPU;
        else if (eff[RQ_BLIT_LO]) winner = OWN_BLIT;
        else if (eff[RQ_CPU])     winner = OWN_CPU;
    end

endmodule

// File: rtl/bus_arb.sv
// Fixed-priority bus arbiter with cycle-boundary release, blitter burst
// limiting, a one-cycle turnaround and a sticky protocol-error flag.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic       clk,
    input  logic       xreset,
    input  logic       op_req,
    input  logic [1:0] blit_breq,
    input  logic       dsp_req,
    input  logic       gpu_req,
    input  logic       cpu_req,
    input  logic       mreq,
    input  logic       ack,
    output logic       op_back,
    output logic       blit_back,
    output logic       dsp_back,
    output logic       gpu_back,
    output logic       cpu_back,
    output logic [2:0] owner,
    output logic       arb_err
);

    localparam int unsigned CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

    arb_state_t         state;
    logic [4:0]         back_q;
    logic               outstanding;
    logic [CW-1:0]      burst_cnt;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] req_vec;
    logic [2:0]         winner;

    logic in_grant, blit_normal, others, ack_ok, own_drop, preempt;
    logic burst_hit, count_ack, boundary, release_now, err_now;

    assign req_vec = {cpu_req, blit_breq[0] & ~blit_breq[1], gpu_req,
                      dsp_req, blit_breq[1], op_req};

    bus_arb_prio u_prio (
        .req    (req_vec),
        .mask   (mask),
        .winner (winner)
    );

    assign in_grant    = (state == ST_GRANT);
    assign blit_normal = (owner == OWN_BLIT) && !blit_breq[1];
    assign others      = op_req | dsp_req | gpu_req | cpu_req;
    assign ack_ok      = ack && (outstanding || mreq);

    always_comb begin
        own_drop = 1'b1;
        case (owner)
            OWN_OP:   own_drop = !op_req;
            OWN_BLIT: own_drop = (blit_breq == 2'b00);
            OWN_DSP:  own_drop = !dsp_req;
            OWN_GPU:  own_drop = !gpu_req;
            OWN_CPU:  own_drop = !cpu_req;
            default:  own_drop = 1'b1;
        endcase
    end

    // Only normal-priority blit and the CPU can be displaced by a higher requester
    assign preempt = (blit_normal && (op_req || dsp_req || gpu_req)) ||
                     ((owner == OWN_CPU) && (op_req || (|blit_breq) || dsp_req || gpu_req));

    assign count_ack = in_grant && ack_ok && blit_normal && others && (burst_cnt < BURST_LIM);
    assign burst_hit = blit_normal && (burst_cnt >= BURST_LIM);

    // An ack this cycle retires the outstanding access, so it counts as a boundary
    assign boundary    = !mreq && (!outstanding || ack);
    assign release_now = in_grant && boundary && (own_drop || preempt || burst_hit);
    assign err_now     = (mreq && !in_grant) || (ack && !outstanding && !(mreq && in_grant));

    always_ff @(posedge clk) begin
        if (xreset) begin
            state       <= ST_IDLE;
            back_q      <= '0;
            owner       <= OWN_NONE;
            outstanding <= 1'b0;
            burst_cnt   <= '0;
            arb_err     <= 1'b0;
            mask        <= '0;
        end else begin
            if (err_now)
                arb_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    mask <= '0;
                    if (winner != OWN_NONE) begin
                        state       <= ST_GRANT;
                        owner       <= winner;
                        back_q      <= owner_onehot(winner);
                        burst_cnt   <= '0;
                        outstanding <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (mreq)
                        outstanding <= !ack;
                    else if (ack)
                        outstanding <= 1'b0;
                    if (count_ack)
                        burst_cnt <= burst_cnt + 1'b1;
                    if (release_now) begin
                        state  <= ST_TURN;
                        owner  <= OWN_NONE;
                        back_q <= '0;
                        if (burst_hit)
                            mask <= BLIT_MASK;
                    end
                end
                ST_TURN: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign op_back   = back_q[0];
    assign blit_back = back_q[1];
    assign dsp_back  = back_q[2];
    assign gpu_back  = back_q[3];
    assign cpu_back  = back_q[4];

endmodule

// File: tb/tb_bus_arb.sv
// Scoreboard bench for bus_arb: each driven cycle queues the grant state
// expected after the next clock edge; a monitor pops and compares it.
module tb_bus_arb;
    import bus_arb_pkg::*;

    logic       clk = 1'b0;
    logic       xreset;
    logic       op_req, dsp_req, gpu_req, cpu_req, mreq, ack;
    logic [1:0] blit_breq;
    logic       op_back, blit_back, dsp_back, gpu_back, cpu_back, arb_err;
    logic [2:0] owner;
    logic [4:0] back_vec;

    localparam logic [4:0] B0  = 5'b00000;
    localparam logic [4:0] BOP = 5'b00001;
    localparam logic [4:0] BBL = 5'b00010;
    localparam logic [4:0] BDS = 5'b00100;
    localparam logic [4:0] BGP = 5'b01000;
    localparam logic [4:0] BCP = 5'b10000;

    always #5 clk = ~clk;

    bus_arb #(.BURST_MAX(16)) dut (
        .clk       (clk),
        .xreset    (xreset),
        .op_req    (op_req),
        .blit_breq (blit_breq),
        .dsp_req   (dsp_req),
        .gpu_req   (gpu_req),
        .cpu_req   (cpu_req),
        .mreq      (mreq),
        .ack       (ack),
        .op_back   (op_back),
        .blit_back (blit_back),
        .dsp_back  (dsp_back),
        .gpu_back  (gpu_back),
        .cpu_back  (cpu_back),
        .owner     (owner),
        .arb_err   (arb_err)
    );

    assign back_vec = {cpu_back, gpu_back, dsp_back, blit_back, op_back};

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [8:0]  exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle  = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got back=%b owner=%0d err=%b, expected back=%b owner=%0d err=%b",
                     tag, got[8:4], got[3:1], got[0], exp[8:4], exp[3:1], exp[0]);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            while (sb.size() > 0 && sb[0].cyc <= cycle) begin
                e = sb.pop_front();
                chk(e.tag, {back_vec, owner, arb_err}, e.exp);
            end
        end
    end

    task automatic reqs(input logic o, input logic [1:0] b, input logic d, input logic g, input logic c);
        op_req = o; blit_breq = b; dsp_req = d; gpu_req = g; cpu_req = c;
    endtask

    task automatic bus(input logic m, input logic a);
        mreq = m; ack = a;
    endtask

    task automatic step(input string tag, input logic [4:0] eb, input logic [2:0] eo, input logic ee);
        exp_t e;
        e.cyc = cycle + 1;
        e.tag = tag;
        e.exp = {eb, eo, ee};
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        xreset = 1'b1;
        reqs(0, 2'b00, 0, 0, 0);
        bus(0, 0);
        @(posedge clk);
        #2;
        step("rst", B0, OWN_NONE, 0);
        xreset = 1'b0;
        step("idle", B0, OWN_NONE, 0);

        // simple grant and release, request during TURN waits for IDLE
        reqs(0, 2'b00, 0, 0, 1); step("cpu_gnt", BCP, OWN_CPU, 0);
        step("cpu_hold", BCP, OWN_CPU, 0);
        reqs(0, 2'b00, 0, 0, 0); step("cpu_rel", B0, OWN_NONE, 0);
        reqs(0, 2'b00, 0, 1, 0); step("turn", B0, OWN_NONE, 0);
        step("gpu_gnt", BGP, OWN_GPU, 0);
        reqs(0, 2'b00, 0, 0, 0); step("gpu_rel", B0, OWN_NONE, 0);
        step("idle2", B0, OWN_NONE, 0);

        // CPU preempted by OP only at the cycle boundary
        reqs(0, 2'b00, 0, 0, 1); step("p_cpu", BCP, OWN_CPU, 0);
        bus(1, 0); step("p_mreq", BCP, OWN_CPU, 0);
        reqs(1, 2'b00, 0, 0, 1); bus(0, 0); step("p_wait", BCP, OWN_CPU, 0);
        bus(0, 1); step("p_ack", B0, OWN_NONE, 0);
        bus(0, 0); step("p_turn", B0, OWN_NONE, 0);
        step("p_op", BOP, OWN_OP, 0);
        reqs(0, 2'b00, 0, 0, 1); step("p_oprel", B0, OWN_NONE, 0);
        step("p_idle", B0, OWN_NONE, 0);
        step("p_cpu2", BCP, OWN_CPU, 0);
        reqs(0, 2'b00, 0, 0, 0); step("p_cpurel", B0, OWN_NONE, 0);
        step("p_idle2", B0, OWN_NONE, 0);

        // burst limit against a lower-priority CPU waiter, with bit1 override
        reqs(0, 2'b01, 0, 0, 1); step("b_gnt", BBL, OWN_BLIT, 0);
        bus(1, 1);
        for (int i = 0; i < 15; i++) step("b_ack", BBL, OWN_BLIT, 0);
        bus(0, 0); step("b_pause15", BBL, OWN_BLIT, 0);
        bus(1, 1); step("b_ack16", BBL, OWN_BLIT, 0);
        reqs(0, 2'b11, 0, 0, 1); bus(0, 0); step("b_hi", BBL, OWN_BLIT, 0);
        step("b_hi2", BBL, OWN_BLIT, 0);
        reqs(0, 2'b01, 0, 0, 1); step("b_lim", B0, OWN_NONE, 0);
        step("b_turn", B0, OWN_NONE, 0);
        step("b_mask", BCP, OWN_CPU, 0);
        step("b_cpu_pre", B0, OWN_NONE, 0);
        step("b_idle", B0, OWN_NONE, 0);
        step("b_regain", BBL, OWN_BLIT, 0);
        reqs(0, 2'b00, 0, 0, 0); step("b_rel", B0, OWN_NONE, 0);
        step("b_idle2", B0, OWN_NONE, 0);

        // burst with GPU waiting; blit regains only after GPU releases
        reqs(0, 2'b01, 0, 0, 0); step("g_blit", BBL, OWN_BLIT, 0);
        reqs(0, 2'b01, 0, 1, 0); bus(1, 1);
        for (int i = 0; i < 16; i++) step("g_ack", BBL, OWN_BLIT, 0);
        bus(0, 0); step("g_drop", B0, OWN_NONE, 0);
        step("g_turn", B0, OWN_NONE, 0);
        step("g_gpu", BGP, OWN_GPU, 0);
        step("g_hold", BGP, OWN_GPU, 0);
        reqs(0, 2'b01, 0, 0, 0); step("g_gpurel", B0, OWN_NONE, 0);
        step("g_idle", B0, OWN_NONE, 0);
        step("g_blit2", BBL, OWN_BLIT, 0);
        reqs(0, 2'b00, 0, 0, 0); step("g_rel", B0, OWN_NONE, 0);
        step("g_idle2", B0, OWN_NONE, 0);

        // DSP is never preempted by OP
        reqs(0, 2'b00, 1, 0, 0); step("d_gnt", BDS, OWN_DSP, 0);
        reqs(1, 2'b00, 1, 0, 0);
        for (int i = 0; i < 50; i++) step("d_hold", BDS, OWN_DSP, 0);
        reqs(1, 2'b00, 0, 0, 0); step("d_rel", B0, OWN_NONE, 0);
        step("d_turn", B0, OWN_NONE, 0);
        step("d_op", BOP, OWN_OP, 0);
        reqs(0, 2'b00, 0, 0, 0); step("d_oprel", B0, OWN_NONE, 0);
        step("d_idle", B0, OWN_NONE, 0);

        // protocol errors and reset during an outstanding cycle
        bus(0, 1); step("e_ack", B0, OWN_NONE, 1);
        bus(0, 0); step("e_hold", B0, OWN_NONE, 1);
        reqs(0, 2'b00, 0, 1, 0); step("e_gpu", BGP, OWN_GPU, 1);
        bus(1, 0); step("e_out", BGP, OWN_GPU, 1);
        xreset = 1'b1; bus(0, 0); step("e_rst", B0, OWN_NONE, 0);
        xreset = 1'b0; step("e_regnt", BGP, OWN_GPU, 0);
        reqs(0, 2'b00, 0, 0, 0); step("e_rel", B0, OWN_NONE, 0);
        step("e_idle", B0, OWN_NONE, 0);
        bus(1, 0); step("e_mreq", B0, OWN_NONE, 1);
        bus(0, 0); step("e_mhold", B0, OWN_NONE, 1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        chk("drain", 9'(sb.size()), 9'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
